// File: rtl/e203_tcm_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : e203_tcm_bank_ram
// Purpose  : Banked tightly-coupled memory with byte-masked writes, a
//            pipelined read path (optional output register) and a three-state
//            power controller (ACTIVE / LOWPWR / WAKE).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/req_ready - request handshake
//            req_we              - 1 = write, 0 = read
//            req_addr            - word address (low bits select the bank)
//            req_wem, req_wdata  - byte write enables and write data
//            rsp_valid           - one-cycle pulse marking rsp_rdata valid
//            rsp_rdata           - read data, held between responses
//            lp_req, lp_state    - requested and current power mode
//            bank_cs             - one-hot bank select in the acceptance cycle
// Revision : 1.0 - initial release
// ============================================================================
module e203_tcm_bank_ram #(
  parameter int DW       = 32,
  parameter int MW       = DW / 8,
  parameter int AW       = 14,
  parameter int NBANK    = 2,
  parameter int OUT_REG  = 0,
  parameter int WAKE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [MW-1:0]    req_wem,
  input  logic [DW-1:0]    req_wdata,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  input  logic [1:0]       lp_req,
  output logic [1:0]       lp_state,
  output logic [NBANK-1:0] bank_cs
);

  localparam int LOG2_NB = (NBANK > 1) ? $clog2(NBANK) : 0;
  localparam int BW      = (NBANK > 1) ? LOG2_NB : 1;
  localparam int RW      = AW - LOG2_NB;
  localparam int ROWS    = 1 << RW;

  // --------------------------------------------------------------------------
  // Power-mode controller
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_LOWPWR = 2'd1,
    ST_WAKE   = 2'd2
  } pwr_state_e;

  pwr_state_e state_q, state_d;
  logic [1:0] lp_state_q, lp_state_d;
  logic [3:0] wake_cnt_q, wake_cnt_d;
  logic       rd_inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACTIVE;
      lp_state_q <= 2'b00;
      wake_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      lp_state_q <= lp_state_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lp_state_d = lp_state_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        // Sleep is deferred until no read is still inside the pipeline.
        if ((lp_req != 2'b00) && !rd_inflight) begin
          state_d    = ST_LOWPWR;
          lp_state_d = lp_req;
        end
      end
      ST_LOWPWR: begin
        if (lp_req != 2'b00) begin
          lp_state_d = lp_req;
        end else begin
          state_d    = ST_WAKE;
          wake_cnt_d = 4'(WAKE_CYC - 1);
        end
      end
      ST_WAKE: begin
        // lp_req is deliberately ignored here; the wake sequence always runs out.
        if (wake_cnt_q == 4'd0) begin
          state_d    = ST_ACTIVE;
          lp_state_d = 2'b00;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  assign req_ready = (state_q == ST_ACTIVE) && (lp_req == 2'b00);
  assign lp_state  = lp_state_q;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic          accept;
  logic [BW-1:0] bank_idx;
  logic [RW-1:0] row;

  assign accept = req_valid && req_ready;

  if (NBANK == 1) begin : g_one_bank
    assign bank_idx = '0;
    assign row      = req_addr;
  end else begin : g_multi_bank
    assign bank_idx = req_addr[BW-1:0];
    assign row      = req_addr[AW-1:BW];
  end

  assign bank_cs = accept ? (NBANK'(1) << bank_idx) : '0;

  // --------------------------------------------------------------------------
  // Bank arrays: byte-masked write and registered read per bank
  // --------------------------------------------------------------------------
  logic [DW-1:0] bank_rd [NBANK];

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DW-1:0] mem_q [ROWS];
    logic [DW-1:0] rd_q;

    // Array contents are intentionally left without reset.
    always_ff @(posedge clk) begin
      if (bank_cs[b] && req_we) begin
        for (int i = 0; i < MW; i++) begin
          if (req_wem[i]) begin
            mem_q[row][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else if (bank_cs[b] && !req_we) begin
        rd_q <= mem_q[row];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  // --------------------------------------------------------------------------
  // Read pipeline
  // --------------------------------------------------------------------------
  logic          rd_vld_q;
  logic [BW-1:0] rd_sel_q;
  logic [DW-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_sel_q <= '0;
    end else begin
      rd_vld_q <= accept && !req_we;
      if (accept && !req_we) begin
        rd_sel_q <= bank_idx;
      end
    end
  end

  // Bank read registers and the select only move on reads, so this mux
  // already holds its value between responses.
  assign rd_data = bank_rd[rd_sel_q];

  if (OUT_REG != 0) begin : g_out_reg
    logic          out_vld_q;
    logic [DW-1:0] out_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) begin
          out_data_q <= rd_data;
        end
      end
    end

    assign rsp_valid   = out_vld_q;
    assign rsp_rdata   = out_data_q;
    assign rd_inflight = rd_vld_q;
  end else begin : g_no_out_reg
    assign rsp_valid   = rd_vld_q;
    assign rsp_rdata   = rd_data;
    assign rd_inflight = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_e203_tcm_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_tcm_bank_ram
// Purpose  : Directed self-checking bench. Two instances (no output register
//            and with output register) share one stimulus stream; each has its
//            own expectation queue holding read data and due cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_tcm_bank_ram;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int MW = 4;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_wem;
  logic [DW-1:0] req_wdata;
  logic [1:0]    lp_req;

  logic          rdy0, rdy1, vld0, vld1;
  logic [DW-1:0] rd0, rd1;
  logic [1:0]    lps0, lps1;
  logic [NB-1:0] cs0, cs1;

  always #5 clk = ~clk;

  e203_tcm_bank_ram #(.DW(DW), .AW(AW), .NBANK(NB), .OUT_REG(0), .WAKE_CYC(4)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wem(req_wem), .req_wdata(req_wdata), .rsp_valid(vld0),
    .rsp_rdata(rd0), .lp_req(lp_req), .lp_state(lps0), .bank_cs(cs0)
  );

  e203_tcm_bank_ram #(.DW(DW), .AW(AW), .NBANK(NB), .OUT_REG(1), .WAKE_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wem(req_wem), .req_wdata(req_wdata), .rsp_valid(vld1),
    .rsp_rdata(rd1), .lp_req(lp_req), .lp_state(lps1), .bank_cs(cs1)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] model [int];
  int            cyc = 0;
  int            compared = 0;
  int            mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitors: pop on rsp_valid, flag stray or overdue responses.
  always @(negedge clk) begin
    exp_t e;
    if (vld0) begin
      if (q0.size() == 0) begin
        chk("dut0 spurious rsp_valid", 64'(vld0), 64'd0);
      end else begin
        e = q0.pop_front();
        chk("dut0 rsp_rdata", 64'(rd0), 64'(e.data));
        chk("dut0 rsp cycle", 64'(cyc), 64'(e.due));
      end
    end else if (q0.size() != 0 && q0[0].due < cyc) begin
      chk("dut0 rsp_valid missing", 64'(vld0), 64'd1);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (vld1) begin
      if (q1.size() == 0) begin
        chk("dut1 spurious rsp_valid", 64'(vld1), 64'd0);
      end else begin
        e = q1.pop_front();
        chk("dut1 rsp_rdata", 64'(rd1), 64'(e.data));
        chk("dut1 rsp cycle", 64'(cyc), 64'(e.due));
      end
    end else if (q1.size() != 0 && q1[0].due < cyc) begin
      chk("dut1 rsp_valid missing", 64'(vld1), 64'd1);
      void'(q1.pop_front());
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] cur;
    logic [NB-1:0] exp_cs;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wem   = m;
    req_wdata = d;
    cur = model.exists(int'(a)) ? model[int'(a)] : 'x;
    for (int i = 0; i < MW; i++) begin
      if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
    end
    model[int'(a)] = cur;
    exp_cs = NB'(1) << a[0];
    #1;
    chk("wr req_ready", 64'({rdy0, rdy1}), 64'd3);
    chk("dut0 bank_cs wr", 64'(cs0), 64'(exp_cs));
    chk("dut1 bank_cs wr", 64'(cs1), 64'(exp_cs));
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit push1);
    logic [NB-1:0] exp_cs;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wem   = '0;
    q0.push_back(exp_t'{data: model[int'(a)], due: cyc + 1});
    if (push1) q1.push_back(exp_t'{data: model[int'(a)], due: cyc + 2});
    exp_cs = NB'(1) << a[0];
    #1;
    chk("rd req_ready", 64'({rdy0, rdy1}), 64'd3);
    chk("dut0 bank_cs rd", 64'(cs0), 64'(exp_cs));
    chk("dut1 bank_cs rd", 64'(cs1), 64'(exp_cs));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wem   = '0;
    req_wdata = '0;
    lp_req    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset rsp_valid", 64'({vld0, vld1}), 64'd0);
    chk("reset dut0 rsp_rdata", 64'(rd0), 64'd0);
    chk("reset dut1 rsp_rdata", 64'(rd1), 64'd0);
    chk("reset lp_state", 64'({lps0, lps1}), 64'd0);
    chk("reset bank_cs", 64'({cs0, cs1}), 64'd0);
    chk("reset req_ready", 64'({rdy0, rdy1}), 64'd3);

    // Full-word write then immediate read of the same address
    wr(14'h5, 4'b1111, 32'hDEADBEEF);
    rd(14'h5, 1'b1);
    idle(3);
    chk("dut0 rdata hold", 64'(rd0), 64'h0000_0000_DEAD_BEEF);
    chk("dut1 rdata hold", 64'(rd1), 64'h0000_0000_DEAD_BEEF);
    chk("idle bank_cs", 64'({cs0, cs1}), 64'd0);

    // Partial byte-mask write
    wr(14'h12, 4'b1111, 32'h11223344);
    wr(14'h12, 4'b0101, 32'hAABBCCDD);
    rd(14'h12, 1'b1);
    idle(3);

    // Back-to-back reads across both banks
    for (int i = 0; i < 4; i++) wr(AW'(i), 4'b1111, 32'hA0000000 + 32'(i) * 32'h01010101);
    for (int i = 0; i < 4; i++) rd(AW'(i), 1'b1);
    idle(4);

    // Sleep request while a read is in flight
    rd(14'h2, 1'b1);
    req_valid = 1'b0;
    lp_req    = 2'b01;
    #1;
    chk("sleep req_ready", 64'({rdy0, rdy1}), 64'd0);
    chk("sleep lp_state pre", 64'({lps0, lps1}), 64'd0);
    @(posedge clk);
    #1;
    chk("dut0 lp_state light", 64'(lps0), 64'd1);
    chk("dut1 lp_state draining", 64'(lps1), 64'd0);
    chk("drain req_ready", 64'({rdy0, rdy1}), 64'd0);
    @(posedge clk);
    #1;
    chk("dut1 lp_state light", 64'(lps1), 64'd1);

    // Light-sleep to deep-sleep
    lp_req = 2'b10;
    @(posedge clk);
    #1;
    chk("lp_state deep", 64'({lps0, lps1}), 64'({2'b10, 2'b10}));
    idle(3);

    // Wake; a transient lp_req during WAKE must not disturb the sequence
    lp_req = 2'b00;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk("wake lp_state held", 64'({lps0, lps1}), 64'({2'b10, 2'b10}));
        chk("wake req_ready", 64'({rdy0, rdy1}), 64'd0);
      end
      if (n == 2) lp_req = 2'b11;
      if (n == 3) lp_req = 2'b00;
      if (rdy0) break;
    end
    chk("wake cycles to ready", 64'(n), 64'd5);
    chk("dut1 ready after wake", 64'(rdy1), 64'd1);
    chk("lp_state active", 64'({lps0, lps1}), 64'd0);

    // Retention through sleep
    rd(14'h5, 1'b1);
    rd(14'h12, 1'b1);
    rd(14'h3, 1'b1);
    idle(4);

    // Reset one cycle after a read: registered-output instance drops it
    rd(14'h1, 1'b0);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post-rst rsp_valid", 64'({vld0, vld1}), 64'd0);
    chk("post-rst dut1 rsp_rdata", 64'(rd1), 64'd0);
    chk("post-rst dut0 rsp_rdata", 64'(rd0), 64'd0);
    chk("post-rst lp_state", 64'({lps0, lps1}), 64'd0);
    idle(5);

    chk("dut0 queue drained", 64'(q0.size()), 64'd0);
    chk("dut1 queue drained", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
